// File: rtl/fpu_vector_runner.sv
// fpu_vector_runner: run engine that steps a writable table of add/sub test
// vectors through a single-precision add/sub core. It checks each captured
// result and flag set against the expected values and keeps pass/fail
// statistics.
// Optional feature: define FPU_RUN_STOP_ON_FAIL_EN to end a run at the first
// mismatch instead of running every vector.
// Table entry layout:
//   {exp_flags[2:0]=ov,un,zero, exp_z[31:0], op, b[31:0], a[31:0]}
// Write addresses must be below N_VEC.

// Combinational single-precision add/subtract core.
// Rounding is round-to-nearest-even.
// Subnormal inputs are treated as zero.
// A result that would be subnormal is flushed to a signed zero with un=1.
// An exact cancellation returns +0.
module fpu_add_sub_top (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_add_sub,
  output logic [31:0] o_z,
  output logic        o_ov,
  output logic        o_un,
  output logic        o_zero
);

  logic              sign_a, sign_b;
  logic [7:0]        exp_a, exp_b;
  logic [22:0]       frac_a, frac_b;
  logic              nan_a, nan_b, inf_a, inf_b;
  logic [30:0]       mag_a, mag_b;
  logic              swap;
  logic              sign_x, sign_y;
  logic [7:0]        exp_x, exp_y, exp_diff;
  logic [23:0]       man_x, man_y;
  logic [26:0]       ext_x, ext_y, shifted_y, lost_mask;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic              lz_found;
  logic [26:0]       norm;
  logic signed [9:0] exp_norm, exp_final;
  logic              round_up;
  logic [24:0]       man_rnd;

  // Align, add or subtract, normalise, round, then classify the result
  always_comb begin
    sign_a = i_a[31];
    sign_b = i_b[31] ^ i_add_sub;
    exp_a  = i_a[30:23];
    exp_b  = i_b[30:23];
    frac_a = i_a[22:0];
    frac_b = i_b[22:0];
    nan_a  = (exp_a == 8'hFF) && (frac_a != 23'd0);
    nan_b  = (exp_b == 8'hFF) && (frac_b != 23'd0);
    inf_a  = (exp_a == 8'hFF) && (frac_a == 23'd0);
    inf_b  = (exp_b == 8'hFF) && (frac_b == 23'd0);
    mag_a  = (exp_a == 8'd0) ? 31'd0 : i_a[30:0];
    mag_b  = (exp_b == 8'd0) ? 31'd0 : i_b[30:0];
    swap   = mag_b > mag_a;

    if (swap) begin
      sign_x = sign_b;
      exp_x  = exp_b;
      man_x  = (exp_b == 8'd0) ? 24'd0 : {1'b1, frac_b};
      sign_y = sign_a;
      exp_y  = exp_a;
      man_y  = (exp_a == 8'd0) ? 24'd0 : {1'b1, frac_a};
    end else begin
      sign_x = sign_a;
      exp_x  = exp_a;
      man_x  = (exp_a == 8'd0) ? 24'd0 : {1'b1, frac_a};
      sign_y = sign_b;
      exp_y  = exp_b;
      man_y  = (exp_b == 8'd0) ? 24'd0 : {1'b1, frac_b};
    end

    exp_diff  = exp_x - exp_y;
    ext_x     = {man_x, 3'b000};
    ext_y     = {man_y, 3'b000};
    lost_mask = 27'd0;
    if (exp_diff >= 8'd27) begin
      shifted_y = {26'd0, |man_y};
    end else begin
      shifted_y    = ext_y >> exp_diff;
      lost_mask    = (27'd1 << exp_diff) - 27'd1;
      shifted_y[0] = shifted_y[0] | (|(ext_y & lost_mask));
    end

    if (sign_x == sign_y) sum = {1'b0, ext_x} + {1'b0, shifted_y};
    else                  sum = {1'b0, ext_x} - {1'b0, shifted_y};

    lz       = 5'd0;
    lz_found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!lz_found && sum[i]) begin
        lz       = 5'(26 - i);
        lz_found = 1'b1;
      end
    end

    if (sum[27]) begin
      norm     = {sum[27:2], sum[1] | sum[0]};
      exp_norm = $signed({2'b00, exp_x}) + 10'sd1;
    end else begin
      norm     = sum[26:0] << lz;
      exp_norm = $signed({2'b00, exp_x}) - $signed({5'd0, lz});
    end

    round_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    man_rnd   = {1'b0, norm[26:3]} + {24'd0, round_up};
    exp_final = man_rnd[24] ? exp_norm + 10'sd1 : exp_norm;

    o_z    = 32'd0;
    o_ov   = 1'b0;
    o_un   = 1'b0;
    o_zero = 1'b0;
    if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b))) begin
      o_z = 32'h7FC00000;
    end else if (inf_a) begin
      o_z = {sign_a, 8'hFF, 23'd0};
    end else if (inf_b) begin
      o_z = {sign_b, 8'hFF, 23'd0};
    end else if (sum == 28'd0) begin
      o_zero = 1'b1;
    end else if (exp_final >= 10'sd255) begin
      o_z  = {sign_x, 8'hFF, 23'd0};
      o_ov = 1'b1;
    end else if (exp_final <= 10'sd0) begin
      o_z    = {sign_x, 31'd0};
      o_un   = 1'b1;
      o_zero = 1'b1;
    end else begin
      o_z = {sign_x, exp_final[7:0], man_rnd[24] ? man_rnd[23:1] : man_rnd[22:0]};
    end
  end

endmodule

module fpu_vector_runner #(
  parameter int N_VEC    = 8,
  parameter int TICK_DIV = 4,
  parameter int CORE_LAT = 1,
  localparam int AW      = $clog2(N_VEC),
  localparam int CW      = $clog2(N_VEC + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_auto,
  input  logic          i_step,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [99:0]   i_wr_data,
  output logic          o_wr_drop,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_idx,
  output logic [31:0]   o_z,
  output logic [2:0]    o_flags,
  output logic [CW-1:0] o_pass_cnt,
  output logic [CW-1:0] o_fail_cnt,
  output logic          o_any_fail,
  output logic [AW-1:0] o_first_fail
);

  localparam int CNT_MAX = (TICK_DIV > CORE_LAT) ? TICK_DIV : CORE_LAT;
  localparam int CNTW    = $clog2(CNT_MAX + 1);
  localparam logic [CNTW-1:0] LAT_LAST  = CNTW'(CORE_LAT - 1);
  localparam logic [CNTW-1:0] TICK_LAST = CNTW'(TICK_DIV - 1);
  localparam logic [AW-1:0]   IDX_LAST  = AW'(N_VEC - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_EXEC, ST_CHECK, ST_WAIT, ST_DONE
  } state_t;

  state_t          state, next_state;
  logic [99:0]     vec_table [N_VEC];
  logic [99:0]     cur_vec;
  logic [31:0]     op_a, op_b;
  logic            op_sub;
  logic [31:0]     core_z;
  logic            core_ov, core_un, core_zero;
  logic [CNTW-1:0] cnt, cnt_next;
  logic            step_q, step_rise;
  logic            exp_match;
  logic            clear_run, load_ops, capture, do_check, advance;

  assign cur_vec   = vec_table[o_idx];
  assign step_rise = i_step & ~step_q;
  assign exp_match = (o_z == cur_vec[96:65]) && (o_flags == cur_vec[99:97]);
  assign o_busy    = (state == ST_FETCH) || (state == ST_EXEC) ||
                     (state == ST_CHECK) || (state == ST_WAIT);
  assign o_done    = (state == ST_DONE);
  assign o_wr_drop = i_wr_en & o_busy & ~i_rst;

  fpu_add_sub_top u_core (
    .i_a       (op_a),
    .i_b       (op_b),
    .i_add_sub (op_sub),
    .o_z       (core_z),
    .o_ov      (core_ov),
    .o_un      (core_un),
    .o_zero    (core_zero)
  );

  // Table RAM: not reset so the vectors survive i_rst; writes only when not running
  always_ff @(posedge i_clk) begin
    if (i_wr_en && ((state == ST_IDLE) || (state == ST_DONE)))
      vec_table[i_wr_addr] <= i_wr_data;
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic and the datapath strobes for each state
  always_comb begin
    next_state = state;
    clear_run  = 1'b0;
    load_ops   = 1'b0;
    capture    = 1'b0;
    do_check   = 1'b0;
    advance    = 1'b0;
    cnt_next   = '0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          clear_run  = 1'b1;
          next_state = ST_FETCH;
        end
      end
      ST_FETCH: begin
        load_ops   = 1'b1;
        next_state = ST_EXEC;
      end
      ST_EXEC: begin
        if (cnt == LAT_LAST) begin
          capture    = 1'b1;
          next_state = ST_CHECK;
        end else begin
          cnt_next = cnt + CNTW'(1);
        end
      end
      ST_CHECK: begin
        do_check   = 1'b1;
        next_state = ST_WAIT;
`ifdef FPU_RUN_STOP_ON_FAIL_EN
        if (!exp_match) next_state = ST_DONE;
`endif
      end
      ST_WAIT: begin
        if ((i_auto && (cnt == TICK_LAST)) || (!i_auto && step_rise)) begin
          if (o_idx == IDX_LAST) begin
            next_state = ST_DONE;
          end else begin
            advance    = 1'b1;
            next_state = ST_FETCH;
          end
        end else if (i_auto) begin
          cnt_next = cnt + CNTW'(1);
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Operand, capture, scoreboard and dwell-counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt          <= '0;
      step_q       <= 1'b0;
      op_a         <= 32'd0;
      op_b         <= 32'd0;
      op_sub       <= 1'b0;
      o_idx        <= '0;
      o_z          <= 32'd0;
      o_flags      <= 3'd0;
      o_pass_cnt   <= '0;
      o_fail_cnt   <= '0;
      o_any_fail   <= 1'b0;
      o_first_fail <= '0;
    end else begin
      cnt    <= cnt_next;
      step_q <= i_step;
      if (clear_run) begin
        o_idx        <= '0;
        o_pass_cnt   <= '0;
        o_fail_cnt   <= '0;
        o_any_fail   <= 1'b0;
        o_first_fail <= '0;
      end
      if (load_ops) begin
        op_a   <= cur_vec[31:0];
        op_b   <= cur_vec[63:32];
        op_sub <= cur_vec[64];
      end
      if (capture) begin
        o_z     <= core_z;
        o_flags <= {core_ov, core_un, core_zero};
      end
      if (do_check) begin
        if (exp_match) begin
          o_pass_cnt <= o_pass_cnt + CW'(1);
        end else begin
          o_fail_cnt <= o_fail_cnt + CW'(1);
          if (!o_any_fail) begin
            o_any_fail   <= 1'b1;
            o_first_fail <= o_idx;
          end
        end
      end
      if (advance) o_idx <= o_idx + AW'(1);
    end
  end

endmodule

// File: tb/tb_fpu_vector_runner.sv
// tb_fpu_vector_runner: directed-plus-random bench for fpu_vector_runner.
// Expected core results come from integer arithmetic on exactly representable
// operands. The model replays the table to predict counts, indices and run length.
module tb_fpu_vector_runner;

  localparam int N_VEC    = 8;
  localparam int TICK_DIV = 4;
  localparam int CORE_LAT = 1;
  localparam int AW       = 3;
  localparam int CW       = 4;
  localparam int VEC_CLKS = 2 + CORE_LAT + TICK_DIV;

  logic          clk = 1'b0;
  logic          rst, start, auto_mode, step, wr_en;
  logic [AW-1:0] wr_addr;
  logic [99:0]   wr_data;
  logic          wr_drop, busy, done, any_fail;
  logic [AW-1:0] idx, first_fail;
  logic [31:0]   z;
  logic [2:0]    flags;
  logic [CW-1:0] pass_cnt, fail_cnt;

  fpu_vector_runner #(.N_VEC(N_VEC), .TICK_DIV(TICK_DIV), .CORE_LAT(CORE_LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_auto(auto_mode), .i_step(step),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_drop(wr_drop),
    .o_busy(busy), .o_done(done), .o_idx(idx), .o_z(z), .o_flags(flags),
    .o_pass_cnt(pass_cnt), .o_fail_cnt(fail_cnt), .o_any_fail(any_fail),
    .o_first_fail(first_fail)
  );

  always #5 clk = ~clk;

  int total_checks = 0, passed_checks = 0, failed_checks = 0, cyc = 0;
  logic [99:0] tbl_m [N_VEC];
  logic [31:0] res_z [N_VEC];
  logic [2:0]  res_f [N_VEC];
  int          m_pass, m_fail, m_first, m_idx, m_cycles;
  logic        m_any, m_ok;
  logic [31:0] m_z;
  logic [2:0]  m_f;
  int          rv, rk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else begin
      failed_checks++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] int_to_float(input int v);
    logic sgn;
    int   mag, p;
    if (v == 0) return 32'd0;
    sgn = (v < 0);
    mag = sgn ? -v : v;
    p   = 0;
    for (int k = 0; k < 31; k++) if (((mag >> k) & 1) == 1) p = k;
    return {sgn, 8'(127 + p), 23'(mag << (23 - p))};
  endfunction

  function automatic int rnd_int();
    return int'($urandom_range(0, 2097152)) - 1048576;
  endfunction

  // Drive one table write, checking the drop indication before the edge
  task automatic apply_stimulus(input int addr, input logic [99:0] data, input logic exp_drop);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    #1;
    check_output($sformatf("wr_drop_during[%0d]", addr), 32'(wr_drop), 32'(exp_drop));
    tick();
    wr_en = 1'b0;
    #1;
    check_output($sformatf("wr_drop_after[%0d]", addr), 32'(wr_drop), 32'd0);
    if (!exp_drop) tbl_m[addr] = data;
  endtask

  task automatic const_vector(input int i, input logic [31:0] a, input logic [31:0] b,
                              input logic op, input logic [31:0] rz, input logic [2:0] rf);
    res_z[i] = rz;
    res_f[i] = rf;
    apply_stimulus(i, {rf, rz, op, b, a}, 1'b0);
  endtask

  task automatic int_vector(input int i, input int a, input int b, input logic op);
    int s;
    s = op ? a - b : a + b;
    res_z[i] = int_to_float(s);
    res_f[i] = (s == 0) ? 3'b001 : 3'b000;
    apply_stimulus(i, {res_f[i], res_z[i], op, int_to_float(b), int_to_float(a)}, 1'b0);
  endtask

  // Replay the table as the run would, producing expected end-of-run values
  task automatic model_run();
    m_pass = 0; m_fail = 0; m_any = 1'b0; m_first = 0; m_idx = 0; m_cycles = 0;
    m_z = 32'd0; m_f = 3'd0;
    for (int i = 0; i < N_VEC; i++) begin
      m_ok  = (tbl_m[i][96:65] == res_z[i]) && (tbl_m[i][99:97] == res_f[i]);
      m_idx = i;
      m_z   = res_z[i];
      m_f   = res_f[i];
      if (m_ok) m_pass++;
      else begin
        m_fail++;
        if (!m_any) begin m_any = 1'b1; m_first = i; end
      end
`ifdef FPU_RUN_STOP_ON_FAIL_EN
      if (!m_ok) begin
        m_cycles = i * VEC_CLKS + 2 + CORE_LAT;
        break;
      end
`endif
      m_cycles = (i + 1) * VEC_CLKS;
    end
  endtask

  task automatic start_run(input logic auto_v);
    auto_mode = auto_v;
    start     = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 0;
  endtask

  task automatic check_first_vector(input string tag);
    repeat (1 + CORE_LAT) tick();
    check_output({tag, ".busy"},   32'(busy),  32'd1);
    check_output({tag, ".z0"},     z,          res_z[0]);
    check_output({tag, ".flags0"}, 32'(flags), 32'(res_f[0]));
  endtask

  task automatic wait_done(input string tag, input logic check_time);
    while (done !== 1'b1 && cyc < 2000) tick();
    check_output({tag, ".done"}, 32'(done), 32'd1);
    if (check_time) check_output({tag, ".cycles"}, 32'(cyc), 32'(m_cycles));
    check_output({tag, ".busy"},  32'(busy),     32'd0);
    check_output({tag, ".pass"},  32'(pass_cnt), 32'(m_pass));
    check_output({tag, ".fail"},  32'(fail_cnt), 32'(m_fail));
    check_output({tag, ".any"},   32'(any_fail), 32'(m_any));
    if (m_any) check_output({tag, ".first"}, 32'(first_fail), 32'(m_first));
    check_output({tag, ".idx"},   32'(idx),      32'(m_idx));
    check_output({tag, ".z"},     z,             m_z);
    check_output({tag, ".flags"}, 32'(flags),    32'(m_f));
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, ".busy"},  32'(busy),       32'd0);
    check_output({tag, ".done"},  32'(done),       32'd0);
    check_output({tag, ".drop"},  32'(wr_drop),    32'd0);
    check_output({tag, ".idx"},   32'(idx),        32'd0);
    check_output({tag, ".z"},     z,               32'd0);
    check_output({tag, ".flags"}, 32'(flags),      32'd0);
    check_output({tag, ".pass"},  32'(pass_cnt),   32'd0);
    check_output({tag, ".fail"},  32'(fail_cnt),   32'd0);
    check_output({tag, ".any"},   32'(any_fail),   32'd0);
    check_output({tag, ".first"}, 32'(first_fail), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; auto_mode = 1'b1; step = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("idle");

    // Clean table: directed spec vectors, a self-cancelling pair, random integers
    const_vector(0, 32'h41A20000, 32'h41A20000, 1'b1, 32'h00000000, 3'b001);
    const_vector(1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100);
    const_vector(2, 32'h41A20000, 32'h41A20000, 1'b0, 32'h42220000, 3'b000);
    rv = rnd_int();
    int_vector(3, rv, rv, 1'b1);
    for (int i = 4; i < N_VEC; i++) int_vector(i, rnd_int(), rnd_int(), 1'($urandom_range(0, 1)));
    model_run();
    start_run(1'b1);
    check_first_vector("clean");
    wait_done("clean", 1'b1);

    // Manual stepping: no progress without a step, one vector per pulse, EXEC pulses ignored
    start_run(1'b0);
    repeat (20) tick();
    check_output("manual.idle_idx",  32'(idx),  32'd0);
    check_output("manual.idle_busy", 32'(busy), 32'd1);
    check_output("manual.idle_cnt",  32'(pass_cnt) + 32'(fail_cnt), 32'd1);
    step = 1'b1;
    repeat (5) tick();
    step = 1'b0;
    repeat (5) tick();
    check_output("manual.step_idx", 32'(idx), 32'd1);
    check_output("manual.step_cnt", 32'(pass_cnt) + 32'(fail_cnt), 32'd2);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (10) tick();
    check_output("manual.exec_pulse_idx",  32'(idx),  32'd2);
    check_output("manual.exec_pulse_busy", 32'(busy), 32'd1);
    auto_mode = 1'b1;
    wait_done("manual", 1'b0);

    // Corrupt expectations while DONE: these writes must be applied
    apply_stimulus(2, {3'b000, 32'h42220001, 1'b0, 32'h41A20000, 32'h41A20000}, 1'b0);
    rk = 4 + int'($urandom_range(0, 3));
    apply_stimulus(rk, {tbl_m[rk][99:97] ^ 3'b010, tbl_m[rk][96:0]}, 1'b0);
    model_run();
    start_run(1'b1);
    check_first_vector("corrupt");
    wait_done("corrupt", 1'b1);

    // A write while busy is dropped and leaves the table alone
    start_run(1'b1);
    repeat (3) tick();
    apply_stimulus(0, {$urandom(), $urandom(), $urandom(), 4'($urandom())}, 1'b1);
    wait_done("busy_write", 1'b1);

    // The same kind of write in DONE changes the expectations of entry 0
    apply_stimulus(0, {3'($urandom()), $urandom(), tbl_m[0][64:0]}, 1'b0);
    model_run();
    start_run(1'b1);
    check_first_vector("done_write");
    wait_done("done_write", 1'b1);

    // Restore entry 0, then reset in the middle of idx1's EXEC and rerun
    apply_stimulus(0, {res_f[0], res_z[0], 1'b1, 32'h41A20000, 32'h41A20000}, 1'b0);
    start_run(1'b1);
    repeat (VEC_CLKS + 1) tick();
    check_output("midrst.pre_idx",  32'(idx),  32'd1);
    check_output("midrst.pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midrst");
    model_run();
    start_run(1'b1);
    check_first_vector("rerun");
    wait_done("rerun", 1'b1);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
